// File: rtl/imem_ldr_pkg.sv
// imem_loader shared constants: default sizes, FSM state codes and byte lanes.
// Optional checksum support is selected with IMEM_LDR_CHECKSUM_EN.
package imem_ldr_pkg;

   localparam int ISIZE_DEF = 18;
   localparam int ASIZE_DEF = 10;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CNT_HI = 3'd1;
   localparam logic [2:0] S_CNT_LO = 3'd2;
   localparam logic [2:0] S_W_B0   = 3'd3;
   localparam logic [2:0] S_W_B1   = 3'd4;
   localparam logic [2:0] S_W_B2   = 3'd5;
   localparam logic [2:0] S_CHK    = 3'd6;
   localparam logic [2:0] S_FINISH = 3'd7;

   localparam int B2_LSB = 0;
   localparam int B1_LSB = 8;
   localparam int B0_LSB = 16;

   function automatic logic takes_byte(input logic [2:0] s);
      return (s != S_IDLE) && (s != S_FINISH);
   endfunction

endpackage

// File: rtl/imem_ldr_chk.sv
// XOR accumulator over frame bytes; compares the running value with a byte.
// Only instantiated when IMEM_LDR_CHECKSUM_EN is defined.
module imem_ldr_chk (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] din,
   output logic       match
);

   logic [7:0] acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc ^ din;
      end
   end

   assign match = (acc == din);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader; holds the CPU in reset while loading.
// Define IMEM_LDR_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
   import imem_ldr_pkg::*;
#(
   parameter int ISIZE = ISIZE_DEF,
   parameter int ASIZE = ASIZE_DEF
) (
   input  logic             Clk_In,
   input  logic             Rst_n_In,
   input  logic             Start_In,
   input  logic [7:0]       Byte_In,
   input  logic             Byte_Valid_In,
   output logic             Byte_Ready_Out,
   output logic             Wr_En_Out,
   output logic [ASIZE-1:0] Wr_Add_Out,
   output logic [ISIZE-1:0] Wr_Data_Out,
   output logic             Busy_Out,
   output logic             Hold_Cpu_Out,
   output logic             Done_Out,
   output logic             Error_Out
);

   localparam logic [16:0] MAX_N = 17'(2 ** ASIZE);

   logic [2:0]        state;
   logic [7:0]        cnt_hi;
   logic [ASIZE:0]    cnt_q;
   logic [ASIZE:0]    addr_q;
   logic [ISIZE-17:0] b0_q;
   logic [7:0]        b1_q;
   logic              hs;
   logic [16:0]       cnt_full;
   logic              oversize;
   logic              last_word;

   assign Byte_Ready_Out = takes_byte(state);
   assign hs             = Byte_Valid_In & Byte_Ready_Out;
   assign Busy_Out       = (state != S_IDLE);
   assign Hold_Cpu_Out   = Busy_Out;
   assign cnt_full       = {1'b0, cnt_hi, Byte_In};
   assign oversize       = (cnt_full > MAX_N);
   assign last_word      = ((addr_q + 1'b1) == cnt_q);

`ifdef IMEM_LDR_CHECKSUM_EN
   localparam logic [2:0] S_END = S_CHK;

   logic chk_clr;
   logic chk_en;
   logic chk_ok;

   assign chk_clr = (state == S_IDLE) & Start_In;
   assign chk_en  = hs & (state != S_CHK);

   imem_ldr_chk u_chk (
      .clk   (Clk_In),
      .rst_n (Rst_n_In),
      .clr   (chk_clr),
      .en    (chk_en),
      .din   (Byte_In),
      .match (chk_ok)
   );
`else
   localparam logic [2:0] S_END = S_FINISH;
`endif

   always_ff @(posedge Clk_In or negedge Rst_n_In) begin
      if (!Rst_n_In) begin
         state       <= S_IDLE;
         cnt_hi      <= '0;
         cnt_q       <= '0;
         addr_q      <= '0;
         b0_q        <= '0;
         b1_q        <= '0;
         Wr_En_Out   <= 1'b0;
         Wr_Add_Out  <= '0;
         Wr_Data_Out <= '0;
         Done_Out    <= 1'b0;
         Error_Out   <= 1'b0;
      end else begin
         Wr_En_Out <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (Start_In) begin
                  state     <= S_CNT_HI;
                  Error_Out <= 1'b0;
                  addr_q    <= '0;
               end
            end
            S_CNT_HI: begin
               if (hs) begin
                  cnt_hi <= Byte_In;
                  state  <= S_CNT_LO;
               end
            end
            S_CNT_LO: begin
               if (hs) begin
                  cnt_q <= cnt_full[ASIZE:0];
                  if (oversize) begin
                     Error_Out <= 1'b1;
                     state     <= S_FINISH;
                  end else if (cnt_full == '0) begin
                     state <= S_END;
                  end else begin
                     state <= S_W_B0;
                  end
               end
            end
            S_W_B0: begin
               if (hs) begin
                  b0_q  <= Byte_In[ISIZE-17:0];
                  state <= S_W_B1;
               end
            end
            S_W_B1: begin
               if (hs) begin
                  b1_q  <= Byte_In;
                  state <= S_W_B2;
               end
            end
            S_W_B2: begin
               if (hs) begin
                  Wr_Data_Out[ISIZE-1:B0_LSB]      <= b0_q;
                  Wr_Data_Out[B1_LSB+7:B1_LSB]     <= b1_q;
                  Wr_Data_Out[B2_LSB+7:B2_LSB]     <= Byte_In;
                  Wr_Add_Out <= addr_q[ASIZE-1:0];
                  Wr_En_Out  <= 1'b1;
                  addr_q     <= addr_q + 1'b1;
                  state      <= last_word ? S_END : S_W_B0;
               end
            end
`ifdef IMEM_LDR_CHECKSUM_EN
            S_CHK: begin
               if (hs) begin
                  if (!chk_ok) Error_Out <= 1'b1;
                  state <= S_FINISH;
               end
            end
`endif
            S_FINISH: begin
               // two FINISH cycles: Done pulses in the second, Busy still high
               if (Done_Out) begin
                  Done_Out <= 1'b0;
                  state    <= S_IDLE;
               end else begin
                  Done_Out <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Loads the instruction memory from a byte stream, writing one instruction word per three bytes. It sits between a host byte source (UART receiver or debug port) and the write port of the writable 1024x18 instruction RAM in the fetch stage. It holds the CPU in reset while a load is in progress, and signals completion or error.

## Interface
- ISIZE, 18, instruction width; legal range 17..24.
- ASIZE, 10, instruction address width; depth 2^ASIZE words.

Clocking: one clock; reset is asynchronous and active-low.

- Clk_In  input  1  system clock; all state changes on the rising edge.
- Rst_n_In  input  1  asynchronous active-low reset.
- Start_In  input  1  begins a load frame when sampled high in IDLE; ignored otherwise.
- Byte_In  input  8  stream byte.
- Byte_Valid_In  input  1  Byte_In is valid.
- Byte_Ready_Out  output  1  loader accepts a byte; handshake = Valid & Ready in the same cycle.
- Wr_En_Out  output  1  one-cycle write strobe to the instruction RAM.
- Wr_Add_Out  output  ASIZE  write address.
- Wr_Data_Out  output  ISIZE  write data.
- Busy_Out  output  1  frame in progress.
- Hold_Cpu_Out  output  1  equals Busy_Out; holds the CPU in reset.
- Done_Out  output  1  one-cycle pulse at frame end.
- Error_Out  output  1  sticky error flag; cleared on the next accepted Start_In.

## Operation
- Frame format:
  - COUNT_HI, COUNT_LO: word count N, big-endian 16-bit.
  - N groups of three bytes B0, B1, B2:
    - B0[ISIZE-17:0] → data[ISIZE-1:16]; the upper bits of B0 are ignored.
    - B1 → data[15:8].
    - B2 → data[7:0].
- States: IDLE, CNT_HI, CNT_LO, W_B0, W_B1, W_B2, CHK (macro only), FINISH.
- IDLE --Start_In--> CNT_HI. On this transition: clear Error_Out, the address counter and the word counter.
- CNT_HI → CNT_LO → W_B0. Each transition happens on a handshake.
- After CNT_LO, the count is checked:
  - N > 2^ASIZE: set Error_Out, go to FINISH, perform no writes.
  - N = 0: go to CHK if the macro is compiled in, else FINISH.
- W_B0 → W_B1 → W_B2 → W_B0 on handshakes.
- On the W_B2 handshake:
  - latch the assembled word into Wr_Data_Out and the current address into Wr_Add_Out;
  - pulse Wr_En_Out on the next cycle;
  - increment the address and the word counter.
  - After the N-th word, go to CHK (macro) or FINISH instead of W_B0.
- FINISH: pulse Done_Out for one cycle, then go to IDLE.
- Byte_Ready_Out is high in CNT_HI, CNT_LO, W_B0..W_B2 and CHK; low in IDLE and FINISH.
- Valid bytes arriving in IDLE are not accepted.
- The address counter is ASIZE+1 bits wide. Because N ≤ 2^ASIZE, the address never wraps; the last legal write goes to 2^ASIZE−1.

## Timing
- Reset values:
  - Byte_Ready_Out, Wr_En_Out, Busy_Out, Hold_Cpu_Out, Done_Out, Error_Out = 0.
  - Wr_Add_Out, Wr_Data_Out = 0.
  - State = IDLE.
- Start_In high at edge k gives Busy_Out and Byte_Ready_Out high from cycle k+1.
- Wr_En_Out is high in the cycle after the B2 handshake. Wr_Add_Out and Wr_Data_Out are stable during that cycle.
- A word's write strobe and the next word's B0 handshake may fall in the same cycle. No bubble is required, so the loader sustains one byte per cycle.
- Done_Out pulses:
  - without the macro, two cycles after the final byte handshake;
  - with the macro, two cycles after the checksum handshake.
- Busy_Out falls in the cycle after the Done_Out pulse.
- Start_In while Busy_Out is high is ignored.
- Reset mid-frame returns to IDLE immediately with all outputs at their reset values. Any words already written stay in the RAM. The CPU is released.

## Configuration
- IMEM_LDR_CHECKSUM_EN defined:
  - CHK state is present.
  - The byte following the last word (or following COUNT_LO when N = 0) must equal the XOR of all preceding frame bytes, including the count bytes.
  - On mismatch, set Error_Out. Writes already performed are not undone.
  - Go to FINISH in either case.
- Not defined:
  - No CHK state and no checksum byte.
  - Error_Out is set only by an oversized count.

## Structure
- Package imem_ldr_pkg holds:
  - the state enum;
  - default ISIZE/ASIZE constants;
  - the byte-lane bit positions (B0/B1/B2 slice bounds).
- Sub-module imem_ldr_chk (XOR accumulator with clear/enable/compare) is compiled in only under IMEM_LDR_CHECKSUM_EN.
- The FSM and counters live in the top module.

## Test plan
- Basic load:
  - Stimulus: Start; stream 00 02, 03 12 34, 01 AB CD.
  - Response: writes 18'h31234 @0, then 18'h1ABCD @1; Done pulse; Error=0.
- Full depth:
  - Stimulus: N=1024 with data equal to the address.
  - Response: 1024 strobes; last at Wr_Add=1023; no extra write; Done.
- Oversize:
  - Stimulus: N=1025.
  - Response: no Wr_En; Error=1; Done; next Start clears Error.
- Backpressure and gaps:
  - Stimulus: random Valid gaps; Start pulsed mid-frame.
  - Response: write sequence identical to the gap-free run; the extra Start is ignored.
- Reset mid-frame:
  - Stimulus: assert Rst_n_In after B1 of word 5.
  - Response: all outputs 0 asynchronously; no write for word 5; a new frame loads from address 0.
- Checksum (IMEM_LDR_CHECKSUM_EN):
  - Stimulus: the basic frame with a correct XOR byte.
  - Response: Error=0.
  - Stimulus: the same frame with the checksum byte flipped.
  - Response: both words written; Error=1; Done.
